pim_sram_ctrl: RTL and testbench

// Host-side initiator for the 4-row twiddle PIM SRAM macro. Accepts twiddle-load and compute requests over

---
 rtl/pim_pkg.sv | 57 +++++
 rtl/pim_settle_timer.sv | 28 ++
 rtl/pim_sram_ctrl.sv | 155 +++++++++++++++
 tb/tb_pim_sram_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_pkg.sv
// Shared definitions for the PIM SRAM controller slice.
//   - pim_state_t : controller FSM states
//   - N_ROWS and default operand/twiddle/sum widths
//   - packing helpers for the 4-row twiddle and data buses (row 0 in LSBs)
package pim_pkg;

  localparam int unsigned N_ROWS            = 4;
  localparam int unsigned DATA_W_DEF        = 6;
  localparam int unsigned TW_W_DEF          = 5;
  localparam int unsigned OUT_W_DEF         = 14;
  localparam int unsigned SETTLE_CYCLES_DEF = 2;

  typedef enum logic [3:0] {
    IDLE,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    R_SETUP,
    R_STROBE,
    SETTLE,
    CAPTURE,
    RESP
  } pim_state_t;

  function automatic logic [N_ROWS*TW_W_DEF-1:0] pack_tw(
    input logic [TW_W_DEF-1:0] r3,
    input logic [TW_W_DEF-1:0] r2,
    input logic [TW_W_DEF-1:0] r1,
    input logic [TW_W_DEF-1:0] r0
  );
    return {r3, r2, r1, r0};
  endfunction

  function automatic logic [N_ROWS*DATA_W_DEF-1:0] pack_data(
    input logic [DATA_W_DEF-1:0] r3,
    input logic [DATA_W_DEF-1:0] r2,
    input logic [DATA_W_DEF-1:0] r1,
    input logic [DATA_W_DEF-1:0] r0
  );
    return {r3, r2, r1, r0};
  endfunction

  function automatic logic [TW_W_DEF-1:0] tw_row(
    input logic [N_ROWS*TW_W_DEF-1:0] bus,
    input int unsigned                row
  );
    return bus[row*TW_W_DEF +: TW_W_DEF];
  endfunction

  function automatic logic [DATA_W_DEF-1:0] data_row(
    input logic [N_ROWS*DATA_W_DEF-1:0] bus,
    input int unsigned                  row
  );
    return bus[row*DATA_W_DEF +: DATA_W_DEF];
  endfunction

endpackage

// File: rtl/pim_settle_timer.sv
// Settle timer for the macro read path.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load the counter with load_val
//   load_val   : number of cycles to count (0 = idle)
//   done       : high during the last counted cycle (one-cycle pulse)
module pim_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign done = (cnt == 4'd1);

endmodule

// File: rtl/pim_sram_ctrl.sv
// Host-side initiator for the 4-row twiddle PIM SRAM macro.
//   cfg_*      : twiddle-load request (valid/ready)
//   op_*       : compute request with pos/neg operands (valid/ready)
//   res_*      : captured macro sums and signed difference (valid/ready)
//   loaded     : twiddles written since reset
//   sram_*     : registered strobes and buses to the macro; sram_sum_* from it
// Only this block strobes the macro. sram_enable is high for exactly one
// cycle, with write/read and buses set up one cycle before and held after.
module pim_sram_ctrl
  import pim_pkg::*;
#(
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned TW_W          = TW_W_DEF,
  parameter int unsigned OUT_W         = OUT_W_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF  // 1..15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [N_ROWS*TW_W-1:0]     cfg_twiddle,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [N_ROWS*DATA_W-1:0]   op_pos,
  input  logic [N_ROWS*DATA_W-1:0]   op_neg,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [OUT_W-1:0]           res_pos,
  output logic [OUT_W-1:0]           res_neg,
  output logic signed [OUT_W:0]      res_diff,
  output logic                       loaded,
  output logic                       sram_enable,
  output logic                       sram_write,
  output logic                       sram_read,
  output logic [N_ROWS*TW_W-1:0]     sram_twiddle,
  output logic [N_ROWS*DATA_W-1:0]   sram_pos,
  output logic [N_ROWS*DATA_W-1:0]   sram_neg,
  input  logic [OUT_W-1:0]           sram_sum_pos,
  input  logic [OUT_W-1:0]           sram_sum_neg
);

  pim_state_t state, state_nxt;
  logic       run;
  logic       cfg_fire, op_fire;
  logic       timer_load, timer_done;

  // run keeps the ready outputs low while reset is held, even though the
  // state register already sits in IDLE.
  assign cfg_ready = run && (state == IDLE);
  assign op_ready  = cfg_ready && loaded && !cfg_valid;
  assign res_valid = (state == RESP);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign op_fire   = op_valid && op_ready;

  pim_settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (4'(SETTLE_CYCLES - 1)),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The strobe cycle counts as the first settle cycle, so SETTLE itself
  // lasts SETTLE_CYCLES-1 cycles and is skipped entirely when that is zero.
  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_fire) begin
          state_nxt = W_SETUP;
        end else if (op_fire) begin
          state_nxt = R_SETUP;
        end
      end
      W_SETUP:  state_nxt = W_STROBE;
      W_STROBE: state_nxt = W_HOLD;
      W_HOLD:   state_nxt = IDLE;
      R_SETUP:  state_nxt = R_STROBE;
      R_STROBE: begin
        if (SETTLE_CYCLES > 1) begin
          state_nxt  = SETTLE;
          timer_load = 1'b1;
        end else begin
          state_nxt = CAPTURE;
        end
      end
      SETTLE: begin
        if (timer_done) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: state_nxt = RESP;
      RESP: begin
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run          <= 1'b0;
      loaded       <= 1'b0;
      sram_enable  <= 1'b0;
      sram_write   <= 1'b0;
      sram_read    <= 1'b0;
      sram_twiddle <= '0;
      sram_pos     <= '0;
      sram_neg     <= '0;
      res_pos      <= '0;
      res_neg      <= '0;
      res_diff     <= '0;
    end else begin
      run         <= 1'b1;
      // Enable is registered from the next state so it is high exactly
      // while the FSM sits in a strobe state.
      sram_enable <= (state_nxt == W_STROBE) || (state_nxt == R_STROBE);
      unique case (state)
        IDLE: begin
          if (cfg_fire) begin
            sram_write   <= 1'b1;
            sram_twiddle <= cfg_twiddle;
          end else if (op_fire) begin
            sram_read <= 1'b1;
            sram_pos  <= op_pos;
            sram_neg  <= op_neg;
          end
        end
        W_HOLD: begin
          sram_write <= 1'b0;
          loaded     <= 1'b1;
        end
        CAPTURE: begin
          sram_read <= 1'b0;
          res_pos   <= sram_sum_pos;
          res_neg   <= sram_sum_neg;
          res_diff  <= $signed({1'b0, sram_sum_pos}) - $signed({1'b0, sram_sum_neg});
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pim_sram_ctrl.sv
module tb_pim_sram_ctrl;
  import pim_pkg::*;

  localparam int unsigned DATA_W = 6;
  localparam int unsigned TW_W   = 5;
  localparam int unsigned OUT_W  = 14;
  localparam int unsigned SETTLE = 2;

  logic                     clk;
  logic                     rst_n;
  logic                     cfg_valid, cfg_ready;
  logic [N_ROWS*TW_W-1:0]   cfg_twiddle;
  logic                     op_valid, op_ready;
  logic [N_ROWS*DATA_W-1:0] op_pos, op_neg;
  logic                     res_valid, res_ready;
  logic [OUT_W-1:0]         res_pos, res_neg;
  logic signed [OUT_W:0]    res_diff;
  logic                     loaded;
  logic                     sram_enable, sram_write, sram_read;
  logic [N_ROWS*TW_W-1:0]   sram_twiddle;
  logic [N_ROWS*DATA_W-1:0] sram_pos, sram_neg;
  logic [OUT_W-1:0]         sram_sum_pos, sram_sum_neg;

  logic                     use_macro;
  logic [OUT_W-1:0]         stub_pos, stub_neg;
  logic [OUT_W-1:0]         mac_pos, mac_neg;
  logic [TW_W-1:0]          mac_tw [N_ROWS];

  int checks = 0;
  int errors = 0;
  int lat;

  pim_sram_ctrl #(
    .DATA_W        (DATA_W),
    .TW_W          (TW_W),
    .OUT_W         (OUT_W),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_twiddle  (cfg_twiddle),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_pos       (op_pos),
    .op_neg       (op_neg),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_pos      (res_pos),
    .res_neg      (res_neg),
    .res_diff     (res_diff),
    .loaded       (loaded),
    .sram_enable  (sram_enable),
    .sram_write   (sram_write),
    .sram_read    (sram_read),
    .sram_twiddle (sram_twiddle),
    .sram_pos     (sram_pos),
    .sram_neg     (sram_neg),
    .sram_sum_pos (sram_sum_pos),
    .sram_sum_neg (sram_sum_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural macro: acts on the rising edge of enable; an edge with
  // neither write nor read clears the stored twiddles.
  always @(posedge sram_enable) begin
    checks++;
    assert (sram_write || sram_read) else begin
      errors++;
      $error("FAIL enable_rise_mode observed write=%0b read=%0b expected write or read set",
             sram_write, sram_read);
    end
    if (sram_write) begin
      for (int i = 0; i < int'(N_ROWS); i++) mac_tw[i] = tw_row(sram_twiddle, i);
    end else if (!sram_read) begin
      for (int i = 0; i < int'(N_ROWS); i++) mac_tw[i] = '0;
    end
  end

  always_comb begin
    mac_pos = '0;
    mac_neg = '0;
    for (int i = 0; i < int'(N_ROWS); i++) begin
      mac_pos = mac_pos + OUT_W'(mac_tw[i]) * OUT_W'(data_row(sram_pos, i));
      mac_neg = mac_neg + OUT_W'(mac_tw[i]) * OUT_W'(data_row(sram_neg, i));
    end
  end

  assign sram_sum_pos = use_macro ? mac_pos : stub_pos;
  assign sram_sum_neg = use_macro ? mac_neg : stub_neg;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_twiddle = '0;
    op_valid    = 1'b0;
    op_pos      = '0;
    op_neg      = '0;
    res_ready   = 1'b0;
    use_macro   = 1'b0;
    stub_pos    = '0;
    stub_neg    = '0;

    // Reset held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_enable", sram_enable, 0);
    chk("rst_write", sram_write, 0);
    chk("rst_read", sram_read, 0);
    chk("rst_twiddle", sram_twiddle, 0);
    chk("rst_diff", res_diff, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_cfg_ready", cfg_ready, 1);
    chk("post_rst_op_ready", op_ready, 0);

    // Op before any load stalls
    op_valid = 1'b1;
    op_pos   = pack_data(6'd4, 6'd3, 6'd2, 6'd1);
    op_neg   = pack_data(6'd1, 6'd1, 6'd1, 6'd1);
    tick();
    tick();
    chk("stall_op_ready", op_ready, 0);
    chk("stall_no_read", sram_read, 0);

    // Simultaneous load and op: load wins
    cfg_valid   = 1'b1;
    cfg_twiddle = pack_tw(5'd3, 5'd7, 5'd1, 5'd31);
    #1;
    chk("simul_op_ready", op_ready, 0);
    chk("simul_cfg_ready", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    chk("wsetup_write", sram_write, 1);
    chk("wsetup_enable", sram_enable, 0);
    chk("wsetup_twiddle", sram_twiddle, {5'd3, 5'd7, 5'd1, 5'd31});
    chk("wsetup_cfg_ready", cfg_ready, 0);
    tick();
    chk("wstrobe_enable", sram_enable, 1);
    chk("wstrobe_write", sram_write, 1);
    tick();
    chk("whold_enable", sram_enable, 0);
    chk("whold_write", sram_write, 1);
    chk("whold_loaded", loaded, 0);
    tick();
    chk("load_done_loaded", loaded, 1);
    chk("load_done_cfg_ready", cfg_ready, 1);
    chk("load_done_write", sram_write, 0);
    chk("load_done_op_ready", op_ready, 1);

    // Compute +70
    stub_pos  = 14'd100;
    stub_neg  = 14'd30;
    res_ready = 1'b1;
    tick();
    op_valid = 1'b0;
    lat = 1;
    chk("rsetup_read", sram_read, 1);
    chk("rsetup_enable", sram_enable, 0);
    chk("rsetup_pos_bus", sram_pos, {6'd4, 6'd3, 6'd2, 6'd1});
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("op_latency", lat, 3 + SETTLE);
    chk("c1_res_pos", res_pos, 100);
    chk("c1_res_neg", res_neg, 30);
    chk("c1_res_diff", $signed(res_diff), 70);
    tick();
    chk("c1_resp_one_cycle", res_valid, 0);
    chk("c1_back_idle", cfg_ready, 1);

    // Compute -16378, then hold res_ready low
    stub_pos  = 14'd5;
    stub_neg  = 14'd16383;
    res_ready = 1'b0;
    op_valid  = 1'b1;
    op_pos    = pack_data(6'd63, 6'd0, 6'd0, 6'd0);
    tick();
    op_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("c2_latency", lat, 3 + SETTLE);
    chk("c2_res_diff", $signed(res_diff), -16378);
    chk("c2_res_neg", res_neg, 16383);
    stub_pos = '0;
    stub_neg = '0;
    op_valid = 1'b1;
    repeat (10) tick();
    chk("hold_res_valid", res_valid, 1);
    chk("hold_res_pos", res_pos, 5);
    chk("hold_res_diff", $signed(res_diff), -16378);
    chk("hold_op_ready", op_ready, 0);
    chk("hold_cfg_ready", cfg_ready, 0);
    op_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    chk("hold_release", res_valid, 0);

    // Reset during SETTLE
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    tick();
    tick();
    chk("settle_read", sram_read, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_loaded", loaded, 0);
    chk("midrst_read", sram_read, 0);
    chk("midrst_enable", sram_enable, 0);
    chk("midrst_pos_bus", sram_pos, 0);
    chk("midrst_res_pos", res_pos, 0);
    chk("midrst_res_diff", res_diff, 0);
    chk("midrst_cfg_ready", cfg_ready, 0);
    rst_n = 1'b1;
    tick();
    op_valid = 1'b1;
    #1;
    chk("reload_needed_op_ready", op_ready, 0);
    chk("reload_cfg_ready", cfg_ready, 1);

    // Behavioural macro: twiddles all 1
    op_valid    = 1'b0;
    use_macro   = 1'b1;
    cfg_valid   = 1'b1;
    cfg_twiddle = pack_tw(5'd1, 5'd1, 5'd1, 5'd1);
    tick();
    cfg_valid = 1'b0;
    lat = 1;
    while (!cfg_ready && lat < 20) begin
      tick();
      lat++;
    end
    chk("mac_load_latency", lat, 4);
    chk("mac_loaded", loaded, 1);
    op_pos    = pack_data(6'd63, 6'd63, 6'd63, 6'd63);
    op_neg    = pack_data(6'd1, 6'd2, 6'd3, 6'd4);
    op_valid  = 1'b1;
    res_ready = 1'b1;
    tick();
    op_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("mac_latency", lat, 3 + SETTLE);
    chk("mac_res_pos", res_pos, 252);
    chk("mac_res_neg", res_neg, 10);
    chk("mac_res_diff", $signed(res_diff), 242);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
